// File: rtl/chipbus_arbiter_if.sv
// chipbus_arbiter_if: CPU handshake, region flags, slot strobes and DMA status shared with the chip-bus arbiter
interface chipbus_arbiter_if;
    logic cck;
    logic e;
    logic cpu_req;
    logic cpu_chip;
    logic cpu_cia;
    logic dma;
    logic dmapri;
    logic cpu_ack;
    logic cpu_wait;
    logic slot_cpu;
    logic starve;

    modport master (
        output cck, e, cpu_req, cpu_chip, cpu_cia, dma, dmapri,
        input  cpu_ack, cpu_wait, slot_cpu, starve
    );

    modport slave (
        input  cck, e, cpu_req, cpu_chip, cpu_cia, dma, dmapri,
        output cpu_ack, cpu_wait, slot_cpu, starve
    );
endinterface

// File: rtl/chipbus_arbiter.sv
// chipbus_arbiter: sequences CPU bus cycles across chip-bus slots, E-clock aligned CIA accesses and zero-wait regions
module chipbus_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 3
) (
    input logic              clk,
    input logic              reset_n,
    chipbus_arbiter_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SLOT_WAIT = 3'd1;
    localparam logic [2:0] CHIP_ACC  = 3'd2;
    localparam logic [2:0] CIA_SYNC  = 3'd3;
    localparam logic [2:0] CIA_ACC   = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             slot_q, slot_d;
    logic             starve_q, starve_d;

    // next state; a dropped request in any waiting state aborts to IDLE without ack, keeping the counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        slot_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (bus.cpu_cia) begin
                        state_d = CIA_SYNC;
                    end else if (bus.cpu_chip) begin
                        state_d = SLOT_WAIT;
                    end else begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                    end
                end
            end
            SLOT_WAIT: begin
                if (!bus.cpu_req) begin
                    state_d = IDLE;
                end else if (bus.cck && !bus.dma) begin
                    if (!bus.dmapri || cnt_q == CNT_MAX) begin
                        state_d = CHIP_ACC;
                        cnt_d   = '0;
                        slot_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CHIP_ACC: begin
                if (!bus.cpu_req) begin
                    state_d = IDLE;
                end else if (bus.cck) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                end else begin
                    slot_d = 1'b1;
                end
            end
            CIA_SYNC: begin
                if (!bus.cpu_req) state_d = IDLE;
                else if (bus.e) state_d = CIA_ACC;
            end
            CIA_ACC: begin
                if (!bus.cpu_req) begin
                    state_d = IDLE;
                end else if (bus.e) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                end
            end
            DONE: begin
                if (!bus.cpu_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        starve_d = (cnt_d == CNT_MAX);
    end

    // state, counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            slot_q   <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            slot_q   <= slot_d;
            starve_q <= starve_d;
        end
    end

    // the slot select is gated by the request so an abort releases the bus at once
    assign bus.cpu_ack  = ack_q;
    assign bus.slot_cpu = slot_q && bus.cpu_req;
    assign bus.starve   = starve_q;
    assign bus.cpu_wait = bus.cpu_req && !ack_q &&
                          (state_q == SLOT_WAIT || state_q == CHIP_ACC ||
                           state_q == CIA_SYNC  || state_q == CIA_ACC);
endmodule
